adder_tree_acc: RTL



---
 rtl/adder_tree_acc.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/adder_tree_acc.sv
// Pipelined bfloat16 reduction tree with multi-beat group accumulator.
// BF_adder is the shared combinational bfloat16 adder used by every tree node.

module BF_adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);
  logic [15:0]       big, sml;
  logic [7:0]        eb, es, diff;
  logic [11:0]       sig_b, sig_s, aligned, raw, norm;
  logic              sticky, found;
  logic [3:0]        lz;
  logic signed [9:0] exp_r;
  logic [8:0]        rnd;
  logic              a_nan, b_nan, a_inf, b_inf;

  // Sign-magnitude add with 3 guard bits, round-to-nearest-even, subnormals flushed to zero.
  always_comb begin
    sum     = 16'h0000;
    a_nan   = (a[14:7] == 8'hFF) && (a[6:0] != 7'h00);
    b_nan   = (b[14:7] == 8'hFF) && (b[6:0] != 7'h00);
    a_inf   = (a[14:7] == 8'hFF) && (a[6:0] == 7'h00);
    b_inf   = (b[14:7] == 8'hFF) && (b[6:0] == 7'h00);
    big     = a;
    sml     = b;
    if (b[14:0] > a[14:0]) begin
      big = b;
      sml = a;
    end
    eb      = big[14:7];
    es      = sml[14:7];
    sig_b   = (eb != 8'h00) ? {2'b01, big[6:0], 3'b000} : 12'h000;
    sig_s   = (es != 8'h00) ? {2'b01, sml[6:0], 3'b000} : 12'h000;
    diff    = eb - es;
    aligned = 12'h000;
    sticky  = 1'b0;
    if (diff >= 8'd12) begin
      sticky = |sig_s;
    end else begin
      aligned = sig_s >> diff;
      sticky  = |(sig_s & ((12'h001 << diff) - 12'h001));
    end
    aligned[0] = aligned[0] | sticky;
    raw   = (big[15] == sml[15]) ? (sig_b + aligned) : (sig_b - aligned);
    exp_r = $signed({2'b00, eb});
    lz    = 4'd0;
    found = 1'b0;
    norm  = raw;
    if (raw[11]) begin
      norm  = {1'b0, raw[11:2], raw[1] | raw[0]};
      exp_r = exp_r + 10'sd1;
    end else begin
      for (int i = 10; i >= 0; i--) begin
        if (!found) begin
          if (raw[i]) found = 1'b1;
          else        lz    = lz + 4'd1;
        end
      end
      norm  = raw << lz;
      exp_r = exp_r - $signed({6'b000000, lz});
    end
    rnd = {1'b0, norm[10:3]} + {8'h00, norm[2] & (norm[1] | norm[0] | norm[3])};
    if (rnd[8]) begin
      rnd   = {1'b0, rnd[8:1]};
      exp_r = exp_r + 10'sd1;
    end
    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) sum = 16'h7FC0;
    else if (a_inf)                                              sum = a;
    else if (b_inf)                                              sum = b;
    else if ((eb == 8'h00) || (raw == 12'h000))                  sum = {big[15] & sml[15], 15'h0000};
    else if (exp_r <= 10'sd0)                                    sum = {big[15], 15'h0000};
    else if (exp_r >= 10'sd255)                                  sum = {big[15], 8'hFF, 7'h00};
    else                                                         sum = {big[15], exp_r[7:0], rnd[6:0]};
  end
endmodule

module adder_tree_acc #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_INPUTS = 576
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             in_valid,
  input  logic                             in_first,
  input  logic                             in_last,
  input  logic [DATA_WIDTH*NUM_INPUTS-1:0] in_data,
  output logic                             out_valid,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             group_err
);
  localparam int unsigned LEVELS = $clog2(NUM_INPUTS);

  function automatic int unsigned lvl_cnt(input int unsigned k);
    int unsigned c;
    c = NUM_INPUTS;
    for (int unsigned i = 0; i < k; i++) c = (c + 1) / 2;
    return c;
  endfunction

  // Start index of level k (k >= 1) in the flat node storage.
  function automatic int unsigned lvl_off(input int unsigned k);
    int unsigned o;
    o = 0;
    for (int unsigned m = 1; m < k; m++) o = o + lvl_cnt(m);
    return o;
  endfunction

  localparam int unsigned TOTAL = lvl_off(LEVELS + 1);

  logic [DATA_WIDTH-1:0] in_elem [NUM_INPUTS];
  logic [DATA_WIDTH-1:0] node_d  [TOTAL];
  logic [DATA_WIDTH-1:0] node_q  [TOTAL];
  logic                  node_en [TOTAL];
  logic [LEVELS-1:0]     vld_q, fst_q, lst_q;

  logic [DATA_WIDTH-1:0] acc_q, acc_d, acc_sum, acc_new, tree_sum;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  open_q, open_d, out_valid_q, out_valid_d, group_err_q, group_err_d;
  logic                  t_vld, t_fst, t_lst, start;

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_in
    assign in_elem[gi] = in_data[DATA_WIDTH*(NUM_INPUTS-gi)-1 -: DATA_WIDTH];
  end

  for (genvar gk = 1; gk <= LEVELS; gk++) begin : g_lvl
    localparam int unsigned NIN  = lvl_cnt(gk - 1);
    localparam int unsigned NOUT = lvl_cnt(gk);
    localparam int unsigned OFF  = lvl_off(gk);
    localparam int unsigned POFF = (gk > 1) ? lvl_off(gk - 1) : 0;
    logic en;
    if (gk == 1) begin : g_en_in
      assign en = in_valid & ~flush;
    end else begin : g_en_stage
      assign en = vld_q[gk-2];
    end
    for (genvar gj = 0; gj < NOUT; gj++) begin : g_node
      logic [DATA_WIDTH-1:0] op_a, op_b;
      if (gk == 1) begin : g_src_in
        assign op_a = in_elem[2*gj];
        if (2*gj + 1 < NIN) begin : g_pair
          assign op_b = in_elem[2*gj+1];
        end else begin : g_pad
          assign op_b = '0;
        end
      end else begin : g_src_node
        assign op_a = node_q[POFF+2*gj];
        if (2*gj + 1 < NIN) begin : g_pair
          assign op_b = node_q[POFF+2*gj+1];
        end else begin : g_pad
          assign op_b = '0;
        end
      end
      BF_adder u_add (.a(op_a), .b(op_b), .sum(node_d[OFF+gj]));
      assign node_en[OFF+gj] = en;
    end
  end

  // Tree stage registers load only on an incoming valid beat; sidebands shift every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TOTAL; i++) node_q[i] <= '0;
      vld_q <= '0;
      fst_q <= '0;
      lst_q <= '0;
    end else begin
      for (int unsigned i = 0; i < TOTAL; i++) begin
        if (node_en[i]) node_q[i] <= node_d[i];
      end
      vld_q[0] <= in_valid & ~flush;
      fst_q[0] <= in_valid & in_first;
      lst_q[0] <= in_valid & in_last;
      for (int unsigned k = 1; k < LEVELS; k++) begin
        vld_q[k] <= vld_q[k-1] & ~flush;
        fst_q[k] <= fst_q[k-1];
        lst_q[k] <= lst_q[k-1];
      end
    end
  end

  assign tree_sum = node_q[TOTAL-1];
  assign t_vld    = vld_q[LEVELS-1];
  assign t_fst    = fst_q[LEVELS-1];
  assign t_lst    = lst_q[LEVELS-1];

  BF_adder u_acc_add (.a(acc_q), .b(tree_sum), .sum(acc_sum));

  // A beat restarts the group on first=1 or when no group is open; either mismatch is an error.
  always_comb begin
    acc_d       = acc_q;
    open_d      = open_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    group_err_d = 1'b0;
    start       = t_fst | ~open_q;
    acc_new     = start ? tree_sum : acc_sum;
    if (flush) begin
      acc_d  = '0;
      open_d = 1'b0;
    end else if (t_vld) begin
      acc_d       = acc_new;
      group_err_d = (t_fst == open_q);
      if (t_lst) begin
        out_valid_d = 1'b1;
        out_data_d  = acc_new;
        open_d      = 1'b0;
      end else begin
        open_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      open_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      group_err_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      open_q      <= open_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      group_err_q <= group_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign group_err = group_err_q;
endmodule
